// File: rtl/pktgen_pkg.sv
// Shared types and constants for the AXI-stream packet generator:
// FSM states, the Ethernet/IPv4/UDP header template and its patch offsets.
package pktgen_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR     = 3'd1,
        PAYLOAD = 3'd2,
        GAP     = 3'd3,
        DONE    = 3'd4
    } pktgen_state_e;

    // Byte k of the header lives at bits [8k+7:8k]; bytes 42..63 are zero.
    // MACs 02:..:02 / 02:..:01, IPv4 10.0.0.1 -> 10.0.0.2, UDP 0x10xx -> 0x2000.
    localparam logic [511:0] PKTGEN_HDR_TEMPLATE =
        512'h0000_0000_0020_0010_0200_000a_0100_000a_0000_1140_0040_0000_0000_0045_0008_0100_0000_0002_0200_0000_0002;

    localparam int PKTGEN_LEN_OFS  = 16;
    localparam int PKTGEN_FLOW_OFS = 35;
    localparam int PKTGEN_L2_BYTES = 14;

    // IPv4 total length of a packet spanning 'beats' beats of 'keep_w' bytes.
    function automatic logic [15:0] pktgen_l3_len(input logic [31:0] beats,
                                                  input logic [31:0] keep_w);
        logic [31:0] bytes_v;
        bytes_v = beats * keep_w - 32'(PKTGEN_L2_BYTES);
        return bytes_v[15:0];
    endfunction

endpackage

// File: rtl/axis_pkt_gen_if.sv
// AXI-stream bundle driven by the packet generator.
interface axis_pkt_gen_if #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/pktgen_lfsr.sv
// 7-bit maximal-length LFSR (x^7 + x^6 + 1) used to throttle beat launches.
// Only present when PKTGEN_LFSR_THROTTLE_EN is defined.
`ifdef PKTGEN_LFSR_THROTTLE_EN
module pktgen_lfsr (
    input  logic       clk,
    input  logic       rst,
    output logic [6:0] lfsr
);
    logic [6:0] lfsr_r;

    // Free-running shift register, seeded with 7'h01.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_r <= 7'h01;
        end else begin
            lfsr_r <= {lfsr_r[5:0], lfsr_r[6] ^ lfsr_r[5]};
        end
    end

    assign lfsr = lfsr_r;
endmodule
`endif

// File: rtl/axis_pkt_gen.sv
// AXI-stream Ethernet/IPv4/UDP packet source with quota, inter-packet gap and statistics.
// Optional random launch throttling is enabled with `define PKTGEN_LFSR_THROTTLE_EN.
module axis_pkt_gen
    import pktgen_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int LEN_WIDTH  = 16,
    parameter int FLOW_NUM   = 4,
    parameter int CNT_WIDTH  = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] pkt_beats,
    input  logic [31:0]          pkt_quota,
    input  logic [7:0]           ipg_cycles,
    input  logic [6:0]           throttle_thresh,
    axis_pkt_gen_if.master       m_axis,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] pkt_sent,
    output logic [CNT_WIDTH-1:0] byte_sent
);
    localparam int FLOW_W = (FLOW_NUM > 1) ? $clog2(FLOW_NUM) : 1;

    pktgen_state_e         state_r, state_n;
    logic [LEN_WIDTH-1:0]  len_r, len_n, beat_r, beat_n, hdr_len_s;
    logic [31:0]           seq_r, seq_n, sent_r, sent_n;
    logic [FLOW_W-1:0]     flow_r, flow_n, flow_inc_s, hdr_flow_s;
    logic [7:0]            gap_r, gap_n;
    logic                  tvalid_r, tvalid_n, tlast_r, tlast_n;
    logic [DATA_WIDTH-1:0] tdata_r, tdata_n, hdr_data_s, pay_data_s;
    logic [KEEP_WIDTH-1:0] tkeep_r, tkeep_n;
    logic [15:0]           hdr_l3_len_s;
    logic                  busy_r, done_r;
    logic [CNT_WIDTH-1:0]  pkt_sent_r, byte_sent_r;
    logic                  hs_s, last_hs_s, slot_s, thr_ok_s, quota_hit_s;
    logic                  launch_hdr_s, launch_pay_s;

`ifdef PKTGEN_LFSR_THROTTLE_EN
    logic [6:0] lfsr_s;

    pktgen_lfsr u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .lfsr (lfsr_s)
    );

    assign thr_ok_s = (lfsr_s < throttle_thresh);
`else
    logic unused_thresh_s;

    assign unused_thresh_s = ^throttle_thresh;
    assign thr_ok_s        = 1'b1;
`endif

    assign hs_s        = tvalid_r & m_axis.tready;
    assign last_hs_s   = hs_s & tlast_r;
    assign slot_s      = ~tvalid_r | m_axis.tready;
    assign quota_hit_s = (pkt_quota != 32'd0) && ((sent_r + 32'd1) == pkt_quota);
    assign hdr_len_s   = (pkt_beats == {LEN_WIDTH{1'b0}}) ? LEN_WIDTH'(1'b1) : pkt_beats;
    assign flow_inc_s  = (flow_r == FLOW_W'(FLOW_NUM - 1)) ? {FLOW_W{1'b0}} : flow_r + FLOW_W'(1'b1);
    // A header launched on the tlast handshake already belongs to the next flow.
    assign hdr_flow_s  = last_hs_s ? flow_inc_s : flow_r;
    assign hdr_l3_len_s = pktgen_l3_len(32'(hdr_len_s), 32'(KEEP_WIDTH));
    assign pay_data_s  = DATA_WIDTH'(seq_r + 32'(beat_r));

    // Header beat: template with IPv4 length and flow ID patched in.
    always_comb begin
        hdr_data_s = {DATA_WIDTH{1'b0}};
        hdr_data_s[511:0] = PKTGEN_HDR_TEMPLATE;
        hdr_data_s[PKTGEN_LEN_OFS*8 +: 8]       = hdr_l3_len_s[15:8];
        hdr_data_s[(PKTGEN_LEN_OFS+1)*8 +: 8]   = hdr_l3_len_s[7:0];
        hdr_data_s[PKTGEN_FLOW_OFS*8 +: 8]      = 8'(hdr_flow_s);
    end

    // Next-state and output-register load decisions.
    always_comb begin
        state_n      = state_r;
        len_n        = len_r;
        beat_n       = beat_r;
        seq_n        = seq_r;
        flow_n       = flow_r;
        sent_n       = sent_r;
        gap_n        = gap_r;
        tvalid_n     = tvalid_r;
        tlast_n      = tlast_r;
        tdata_n      = tdata_r;
        tkeep_n      = tkeep_r;
        launch_hdr_s = 1'b0;
        launch_pay_s = 1'b0;

        case (state_r)
            IDLE: begin
                len_n = hdr_len_s;
                if (start) begin
                    state_n = HDR;
                end else begin
                    state_n = IDLE;
                end
            end
            HDR: begin
                launch_hdr_s = thr_ok_s;
            end
            PAYLOAD: begin
                if (last_hs_s) begin
                    seq_n  = seq_r + 32'd1;
                    flow_n = flow_inc_s;
                    sent_n = sent_r + 32'd1;
                    if (quota_hit_s) begin
                        state_n = DONE;
                    end else if (ipg_cycles != 8'd0) begin
                        state_n = GAP;
                        gap_n   = ipg_cycles;
                    end else if (start) begin
                        state_n      = HDR;
                        launch_hdr_s = thr_ok_s;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    launch_pay_s = slot_s && thr_ok_s && (beat_r < len_r);
                end
            end
            GAP: begin
                if (gap_r <= 8'd1) begin
                    if (start) begin
                        state_n      = HDR;
                        launch_hdr_s = thr_ok_s;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    gap_n = gap_r - 8'd1;
                end
            end
            DONE: begin
                if (!start) begin
                    state_n = IDLE;
                    sent_n  = 32'd0;
                end else begin
                    state_n = DONE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (launch_hdr_s) begin
            state_n  = PAYLOAD;
            len_n    = hdr_len_s;
            beat_n   = LEN_WIDTH'(1'b1);
            tvalid_n = 1'b1;
            tdata_n  = hdr_data_s;
            tkeep_n  = {KEEP_WIDTH{1'b1}};
            tlast_n  = (hdr_len_s == LEN_WIDTH'(1'b1));
        end else if (launch_pay_s) begin
            beat_n   = beat_r + LEN_WIDTH'(1'b1);
            tvalid_n = 1'b1;
            tdata_n  = pay_data_s;
            tkeep_n  = {KEEP_WIDTH{1'b1}};
            tlast_n  = (beat_r == (len_r - LEN_WIDTH'(1'b1)));
        end else begin
            tvalid_n = tvalid_r & ~m_axis.tready;
        end
    end

    // State, sequencing and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            len_r    <= LEN_WIDTH'(1'b1);
            beat_r   <= {LEN_WIDTH{1'b0}};
            seq_r    <= 32'd1;
            flow_r   <= {FLOW_W{1'b0}};
            sent_r   <= 32'd0;
            gap_r    <= 8'd0;
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
            tdata_r  <= {DATA_WIDTH{1'b0}};
            tkeep_r  <= {KEEP_WIDTH{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_n;
            len_r    <= len_n;
            beat_r   <= beat_n;
            seq_r    <= seq_n;
            flow_r   <= flow_n;
            sent_r   <= sent_n;
            gap_r    <= gap_n;
            tvalid_r <= tvalid_n;
            tlast_r  <= tlast_n;
            tdata_r  <= tdata_n;
            tkeep_r  <= tkeep_n;
            busy_r   <= (state_n == HDR) || (state_n == PAYLOAD) || (state_n == GAP);
            done_r   <= (state_n == DONE);
        end
    end

    // Statistics counters; they wrap and clear only on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_sent_r  <= {CNT_WIDTH{1'b0}};
            byte_sent_r <= {CNT_WIDTH{1'b0}};
        end else begin
            if (hs_s) begin
                byte_sent_r <= byte_sent_r + CNT_WIDTH'(KEEP_WIDTH);
            end
            if (last_hs_s) begin
                pkt_sent_r <= pkt_sent_r + CNT_WIDTH'(1'b1);
            end
        end
    end

    assign m_axis.tdata  = tdata_r;
    assign m_axis.tkeep  = tkeep_r;
    assign m_axis.tvalid = tvalid_r;
    assign m_axis.tlast  = tlast_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign pkt_sent      = pkt_sent_r;
    assign byte_sent     = byte_sent_r;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed self-checking bench for axis_pkt_gen: framing, quota, gap, backpressure,
// mid-packet stop and reset; the throttle ratio is checked when PKTGEN_LFSR_THROTTLE_EN is defined.
module tb_axis_pkt_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] pkt_beats = 16'd1;
    logic [31:0] pkt_quota = 32'd0;
    logic [7:0]  ipg_cycles = 8'd0;
    logic [6:0]  throttle_thresh = 7'd100;
    logic        busy, done;
    logic [63:0] pkt_sent, byte_sent;

    int n_tests = 0;
    int n_fail  = 0;

    logic [511:0] hs_data[$];
    logic         hs_last[$];
    int           hs_cyc[$];
    int           cyc;
    int           first_vld;
    logic         stall_pend;
    logic [511:0] prev_data;
    logic         prev_last;

    axis_pkt_gen_if #(.DATA_WIDTH(512), .KEEP_WIDTH(64)) axis ();

    axis_pkt_gen #(
        .DATA_WIDTH (512),
        .KEEP_WIDTH (64),
        .LEN_WIDTH  (16),
        .FLOW_NUM   (4),
        .CNT_WIDTH  (64)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .pkt_beats       (pkt_beats),
        .pkt_quota       (pkt_quota),
        .ipg_cycles      (ipg_cycles),
        .throttle_thresh (throttle_thresh),
        .m_axis          (axis),
        .busy            (busy),
        .done            (done),
        .pkt_sent        (pkt_sent),
        .byte_sent       (byte_sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [511:0] d, input int i);
        return d[i*8 +: 8];
    endfunction

    function automatic logic [15:0] len_field(input logic [511:0] d);
        return {byte_of(d, 16), byte_of(d, 17)};
    endfunction

    task automatic clear_log();
        hs_data.delete();
        hs_last.delete();
        hs_cyc.delete();
        cyc        = 0;
        first_vld  = -1;
        stall_pend = 1'b0;
    endtask

    // One clock: drive tready for the coming edge, check hold rules, log the handshake.
    task automatic cycle(input logic rdy);
        @(negedge clk);
        axis.tready = rdy;
        cyc++;
        if (stall_pend) begin
            check("hold_valid", axis.tvalid, 1'b1);
            check("hold_data", axis.tdata, prev_data);
            check("hold_last", axis.tlast, prev_last);
        end
        if (axis.tvalid && first_vld < 0) first_vld = cyc;
        if (axis.tvalid && rdy) begin
            hs_data.push_back(axis.tdata);
            hs_last.push_back(axis.tlast);
            hs_cyc.push_back(cyc);
        end
        stall_pend = axis.tvalid && !rdy;
        prev_data  = axis.tdata;
        prev_last  = axis.tlast;
    endtask

    task automatic do_reset();
        start = 1'b0;
        rst   = 1'b1;
        cycle(1'b1);
        cycle(1'b1);
        rst = 1'b0;
        clear_log();
    endtask

    initial begin
        int guard;
        axis.tready = 1'b1;
        clear_log();
        do_reset();

        // Reset state
        check("rst_tvalid", axis.tvalid, 1'b0);
        check("rst_tlast", axis.tlast, 1'b0);
        check("rst_tdata", axis.tdata, 512'd0);
        check("rst_tkeep", axis.tkeep, 64'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pkt_sent", pkt_sent, 64'd0);
        check("rst_byte_sent", byte_sent, 64'd0);

`ifndef PKTGEN_LFSR_THROTTLE_EN
        // Single-beat packets, quota 3, back to back
        pkt_beats = 16'd1; pkt_quota = 32'd3; ipg_cycles = 8'd0; start = 1'b1;
        for (int i = 0; i < 12; i++) cycle(1'b1);
        check("s1_latency", first_vld, 2);
        check("s1_count", hs_data.size(), 3);
        if (hs_data.size() == 3) begin
            for (int p = 0; p < 3; p++) begin
                check("s1_cyc", hs_cyc[p], 2 + p);
                check("s1_last", hs_last[p], 1'b1);
                check("s1_flow", byte_of(hs_data[p], 35), p);
                check("s1_len", len_field(hs_data[p]), 16'h0032);
            end
            check("s1_ethertype", {byte_of(hs_data[0], 12), byte_of(hs_data[0], 13)}, 16'h0800);
            check("s1_ipver", byte_of(hs_data[0], 14), 8'h45);
            check("s1_proto", byte_of(hs_data[0], 23), 8'h11);
        end
        check("s1_done", done, 1'b1);
        check("s1_busy", busy, 1'b0);
        check("s1_tvalid", axis.tvalid, 1'b0);
        check("s1_tkeep", axis.tkeep, {64{1'b1}});
        check("s1_pkt_sent", pkt_sent, 64'd3);
        check("s1_byte_sent", byte_sent, 64'd192);
        start = 1'b0;
        cycle(1'b1);
        cycle(1'b1);
        check("s1_done_clr", done, 1'b0);

        // 4-beat packets, quota 2, gap 5
        do_reset();
        pkt_beats = 16'd4; pkt_quota = 32'd2; ipg_cycles = 8'd5; start = 1'b1;
        for (int i = 0; i < 40; i++) cycle(1'b1);
        check("s2_count", hs_data.size(), 8);
        if (hs_data.size() == 8) begin
            check("s2_len", len_field(hs_data[0]), 16'h00f2);
            check("s2_flow0", byte_of(hs_data[0], 35), 8'd0);
            check("s2_flow1", byte_of(hs_data[4], 35), 8'd1);
            check("s2_p1b1", hs_data[1], 512'd2);
            check("s2_p1b2", hs_data[2], 512'd3);
            check("s2_p1b3", hs_data[3], 512'd4);
            check("s2_p2b1", hs_data[5], 512'd3);
            check("s2_p2b2", hs_data[6], 512'd4);
            check("s2_p2b3", hs_data[7], 512'd5);
            check("s2_last0", hs_last[0], 1'b0);
            check("s2_last3", hs_last[3], 1'b1);
            check("s2_last7", hs_last[7], 1'b1);
            check("s2_no_bubble", hs_cyc[3] - hs_cyc[0], 3);
            check("s2_gap", hs_cyc[4] - hs_cyc[3] - 1, 5);
        end
        check("s2_byte_sent", byte_sent, 64'd512);
        check("s2_pkt_sent", pkt_sent, 64'd2);
        check("s2_done", done, 1'b1);
`endif

        // Random backpressure, 8-beat packets, quota 20
        do_reset();
        pkt_beats = 16'd8; pkt_quota = 32'd20; ipg_cycles = 8'd0; start = 1'b1;
        guard = 0;
        while (!done && guard < 4000) begin
            cycle(1'($urandom_range(0, 1)));
            guard++;
        end
        check("s3_done", done, 1'b1);
        check("s3_count", hs_data.size(), 160);
        check("s3_pkt_sent", pkt_sent, 64'd20);
        check("s3_byte_sent", byte_sent, 64'd10240);
        if (hs_data.size() == 160) begin
            for (int p = 0; p < 20; p++) begin
                check("s3_flow", byte_of(hs_data[p*8], 35), p % 4);
                check("s3_len", len_field(hs_data[p*8]), 16'h01f2);
                for (int b = 1; b < 8; b++) check("s3_payload", hs_data[p*8 + b], p + 1 + b);
                check("s3_last", hs_last[p*8 + 7], 1'b1);
            end
        end
        start = 1'b0;
        cycle(1'b1);

        // start dropped on beat 2 of a 6-beat packet
        do_reset();
        axis.tready = 1'b1;
        pkt_beats = 16'd6; pkt_quota = 32'd0; ipg_cycles = 8'd0; start = 1'b1;
        guard = 0;
        while (hs_data.size() < 2 && guard < 200) begin
            cycle(1'b1);
            guard++;
        end
        start = 1'b0;
        for (int i = 0; i < 100; i++) cycle(1'b1);
        check("s4_count", hs_data.size(), 6);
        if (hs_data.size() == 6) begin
            check("s4_last4", hs_last[4], 1'b0);
            check("s4_last5", hs_last[5], 1'b1);
        end
        check("s4_tvalid", axis.tvalid, 1'b0);
        check("s4_busy", busy, 1'b0);
        check("s4_pkt_sent", pkt_sent, 64'd1);

        // Reset in the middle of the second packet's payload
        do_reset();
        pkt_beats = 16'd4; pkt_quota = 32'd0; ipg_cycles = 8'd0; start = 1'b1;
        guard = 0;
        while (hs_data.size() < 6 && guard < 300) begin
            cycle(1'b1);
            guard++;
        end
        check("s5_pre_count", hs_data.size(), 6);
        if (hs_data.size() == 6) check("s5_pre_payload", hs_data[5], 512'd3);
        rst = 1'b1;
        cycle(1'b1);
        check("s5_abort_tvalid", axis.tvalid, 1'b0);
        check("s5_abort_busy", busy, 1'b0);
        rst = 1'b0;
        clear_log();
        guard = 0;
        while (hs_data.size() < 2 && guard < 300) begin
            cycle(1'b1);
            guard++;
        end
        check("s5_post_count", hs_data.size(), 2);
        if (hs_data.size() == 2) begin
            check("s5_post_flow", byte_of(hs_data[0], 35), 8'd0);
            check("s5_post_payload", hs_data[1], 512'd2);
        end
        start = 1'b0;
        for (int i = 0; i < 10; i++) cycle(1'b1);

`ifdef PKTGEN_LFSR_THROTTLE_EN
        // LFSR throttling at threshold 64
        do_reset();
        throttle_thresh = 7'd64;
        pkt_beats = 16'd8; pkt_quota = 32'd0; ipg_cycles = 8'd0; start = 1'b1;
        for (int i = 0; i < 1000; i++) cycle(1'b1);
        check("s6_ratio_lo", hs_data.size() >= 400, 1'b1);
        check("s6_ratio_hi", hs_data.size() <= 600, 1'b1);
        start = 1'b0;
        for (int i = 0; i < 100; i++) cycle(1'b1);
        check("s6_idle", busy, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_pkt_gen.md
# axis_pkt_gen

Synthesizable, parametrised AXI-stream packet source for exercising the panic offload pipeline in simulation and on hardware. Emits Ethernet/IPv4/UDP-framed packets of programmable length, with round-robin flow IDs, a programmable inter-packet gap and a programmable packet quota. It also keeps running packet and byte counters. It drives the pipeline's `s_rx_axis_*` input in place of a behavioural stimulus generator.

## Interface
- `DATA_WIDTH`, 512: tdata width in bits; must be ≥ 512 and a multiple of 8.
- `KEEP_WIDTH`, DATA_WIDTH/8: tkeep width.
- `LEN_WIDTH`, 16: width of the packet length, in beats.
- `FLOW_NUM`, 4: number of flow IDs cycled round-robin; range 1..32.
- `CNT_WIDTH`, 64: width of the statistics counters.
- `clk` in 1: clock. Reset: `rst`, synchronous, active-high; clock `clk`.
- `rst` in 1: synchronous active-high reset.
- `start` in 1: level enable; generation runs while high.
- `pkt_beats` in LEN_WIDTH: packet length in beats. Sampled at each header beat; 0 is treated as 1.
- `pkt_quota` in 32: number of packets to send per run; 0 means unlimited.
- `ipg_cycles` in 8: idle cycles after each tlast handshake.
- `throttle_thresh` in 7: valid-launch probability threshold, out of 128. Only used with the macro.
- `m_axis_tdata` out DATA_WIDTH; `m_axis_tkeep` out KEEP_WIDTH; `m_axis_tvalid` out 1; `m_axis_tready` in 1; `m_axis_tlast` out 1.
- `busy` out 1: a packet is in flight or in its gap.
- `done` out 1: the quota has been reached.
- `pkt_sent` out CNT_WIDTH; `byte_sent` out CNT_WIDTH: statistics counters.

## Operation
- States: IDLE, HDR, PAYLOAD, GAP, DONE.
- IDLE:
  - `start`=1 → HDR.
  - Latches `pkt_beats` into `len_q`.
- HDR: emits the header beat.
  - tdata = `PKTGEN_HDR_TEMPLATE`, zero-extended above bit 511.
  - Bytes 16 and 17 = big-endian `(len_q*KEEP_WIDTH - 14)[15:0]`.
  - Byte 35 = current flow ID.
  - tkeep all ones. tlast = (len_q==1).
- PAYLOAD: beat i (1..len_q-1) carries tdata = `seq + i`, zero-extended.
  - `seq` starts at 1 after reset and increments by 1 per packet.
  - tkeep all ones. tlast on beat len_q-1.
- On the tlast handshake:
  - `seq`++, flow ID advances modulo FLOW_NUM, `sent_q`++.
  - If `pkt_quota`≠0 and `sent_q+1`==`pkt_quota` → DONE.
  - Else, if `ipg_cycles`≠0 → GAP. Else → HDR directly, or IDLE if `start`=0.
- GAP: counts down `ipg_cycles` with tvalid=0. Then → HDR if `start`=1, else IDLE.
- DONE: `done`=1 and tvalid=0. When `start` falls → IDLE, and `sent_q` is cleared.
- `start` dropping mid-packet: the current packet completes, then → IDLE. No truncated packets.
- Counters:
  - `pkt_sent`++ on every tlast handshake.
  - `byte_sent` += KEEP_WIDTH on every beat handshake.
  - Both wrap modulo 2^CNT_WIDTH and clear only on `rst`.
- `busy` = state ∈ {HDR, PAYLOAD, GAP}.

## Timing
- All outputs are registered.
- Reset values: tvalid 0, tlast 0, tdata 0, tkeep 0, busy 0, done 0, pkt_sent 0, byte_sent 0. Internal: `seq`=1, flow ID 0, state IDLE.
- `rst` mid-packet aborts immediately: tvalid is 0 the cycle after.
- Latency: `start` sampled high in IDLE at edge N → header tvalid=1 after edge N+1.
- Handshake:
  - Once tvalid=1, tdata/tkeep/tlast are held stable until tready=1.
  - tvalid never drops without a handshake.
- Back-to-back: with `ipg_cycles`=0 and tready=1, throughput is one beat per cycle with no bubble between packets.
- Gap: with `ipg_cycles`=G, exactly G cycles of tvalid=0 separate the tlast handshake from the next header.
- `pkt_beats` changes take effect at the next header only.

## Configuration
- `PKTGEN_LFSR_THROTTLE_EN` defined:
  - A 7-bit maximal LFSR (seed 7'h01, advances every cycle) gates the launch of each beat.
  - A beat is launched only when `lfsr < throttle_thresh`.
  - Once tvalid is asserted it stays asserted until the handshake.
- Undefined: beats launch every eligible cycle, and `throttle_thresh` is ignored.

## Structure
- Package `pktgen_pkg` holds:
  - The state enum.
  - `PKTGEN_HDR_TEMPLATE` (512-bit UDP header constant).
  - Byte offsets `PKTGEN_LEN_OFS`=16 and `PKTGEN_FLOW_OFS`=35.
  - Constant `PKTGEN_L2_BYTES`=14.
- One sub-module: `pktgen_lfsr`, the 7-bit LFSR, instantiated only under the macro.

## Test plan
- `pkt_beats`=1, quota 3, ipg 0, tready=1:
  - Expect 3 single-beat packets on consecutive cycles, flow IDs 0,1,2.
  - Bytes 16–17 = 0x0032. `done`=1 after the third.
- `pkt_beats`=4, quota 2, ipg 5:
  - Payload beats of packet 1 = 2,3,4; packet 2 = 3,4,5.
  - Exactly 5 idle cycles between packets. `byte_sent`=512.
- Random tready backpressure, `pkt_beats`=8, quota 20:
  - tdata/tlast stable while stalled. `pkt_sent`=20. No tvalid drop without a handshake.
- `start` deasserted on beat 2 of 6:
  - Packet completes with tlast on beat 6, then tvalid=0 and `busy`=0.
- `rst` asserted mid-payload:
  - tvalid=0 the next cycle. After release, the next header carries flow 0 and the first payload beat = 2.
- With the macro, `throttle_thresh`=64, 1000 beats, tready=1:
  - Accepted-beat ratio within 40–60%. No protocol violations.
